// File: rtl/data_mem_if.sv
`timescale 1ns/1ps
// data_mem_if
//   Bundles the CPU data-access request and response channels.
//   Request : req_valid, req_ready, req_write, req_addr, req_wdata
//   Response: resp_valid, resp_ready, resp_rdata, resp_err
//   master = CPU side, slave = memory responder side.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// data_mem_responder
//   Memory-side responder for the CPU data port. Accepts one load/store at a
//   time, waits LATENCY cycles, then commits the access and holds the response
//   until the CPU takes it. Misaligned or out-of-range accesses return resp_err.
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : data_mem_if.slave (request and response valid/ready channels)
// Parameters
//   DEPTH   : number of 32-bit words
//   LATENCY : cycles from accept to resp_valid, >= 1
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic      clk,
    input  logic      reset,
    data_mem_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misalignment or word index beyond the array.
    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            lat_write_p0;
    logic [31:0]     lat_addr_p0;
    logic [31:0]     lat_wdata_p0;
    logic            resp_valid_q;
    logic [31:0]     resp_rdata_q;
    logic            resp_err_q;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            commit_en;
    logic            com_write;
    logic [31:0]     com_addr;
    logic [31:0]     com_wdata;
    logic            com_err;
    logic [AW-1:0]   com_idx;

    assign bus.req_ready  = (state_q == IDLE) && reset;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    assign accept = bus.req_valid && bus.req_ready;

    // With LATENCY==1 the commit happens on the accept edge itself, so the
    // access fields come straight from the bus; otherwise from the latch.
    always_comb begin
        if (state_q == IDLE) begin
            com_write = bus.req_write;
            com_addr  = bus.req_addr;
            com_wdata = bus.req_wdata;
        end else begin
            com_write = lat_write_p0;
            com_addr  = lat_addr_p0;
            com_wdata = lat_wdata_p0;
        end
        com_err = addr_err(com_addr);
        com_idx = com_addr[AW+1:2];
    end

    always_comb begin
        state_d   = state_q;
        commit_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d   = RESP;
                        commit_en = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Counter reaches zero on this edge.
                if (cnt_q == CW'(1)) begin
                    state_d   = RESP;
                    commit_en = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lat_write_p0 <= 1'b0;
            lat_addr_p0  <= '0;
            lat_wdata_p0 <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            // Request latch and latency counter
            if (accept) begin
                lat_write_p0 <= bus.req_write;
                lat_addr_p0  <= bus.req_addr;
                lat_wdata_p0 <= bus.req_wdata;
                cnt_q        <= CW'(LATENCY - 1);
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CW'(1);
            end

            // Response register
            if (commit_en) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= com_err;
                if (com_err || com_write) resp_rdata_q <= '0;
                else                      resp_rdata_q <= mem[com_idx];
            end else if ((state_q == RESP) && bus.resp_ready) begin
                resp_valid_q <= 1'b0;
                resp_rdata_q <= '0;
                resp_err_q   <= 1'b0;
            end
        end
    end

    // Array is not reset; commit_en is already low whenever reset is held.
    always_ff @(posedge clk) begin
        if (commit_en && com_write && !com_err) mem[com_idx] <= com_wdata;
    end
endmodule
